uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 208, refclk cycles per bit (2 MHz / 9600 baud).
REQ-002 SHALL provide parameter DATA_BITS, default 8, data bits per frame, LSB first.
REQ-003 SHALL provide port refclk  in  1  single clock, 2 MHz PLL output; all logic on rising edge.
REQ-004 SHALL provide port rst  in  1  synchronous, active-low reset.
REQ-005 SHALL provide port rx  in  1  RS232 line, asynchronous, idle high.
REQ-006 SHALL provide port data  out  DATA_BITS  last received byte, held until next delivery.
REQ-007 SHALL provide port valid  out  1  data holds an unconsumed byte.
REQ-008 SHALL provide port ack  in  1  consumer takes data; ignored while valid=0.
REQ-009 SHALL provide port frame_err  out  1  delivered byte had stop bit sampled low; qualifies data while valid=1.
REQ-010 SHALL provide port overrun  out  1  sticky: a byte completed while valid=1; cleared only by reset.
REQ-011 SHALL provide port busy  out  1  high in every state except IDLE.

Function
REQ-012 rx SHALL pass a 2-flop synchronizer (rx_s), reset value 1; all decisions use rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: rx_s=0 SHALL move to START and load bit counter 0.
REQ-015 START: at count CLKS_PER_BIT/2-1 (cycle 104 after entry), rx_s=1 SHALL return to IDLE (glitch reject, no output change); rx_s=0 SHALL enter DATA with counter 0.
REQ-016 DATA: every CLKS_PER_BIT cycles SHALL shift rx_s into bit index 0..DATA_BITS-1 (LSB first); after bit DATA_BITS-1 SHALL enter STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles SHALL sample rx_s; cycle after sampling, data SHALL load shift register, valid SHALL go 1, frame_err SHALL equal NOT sampled stop bit.
REQ-018 Stop sampled 1 SHALL return to IDLE; stop sampled 0 SHALL enter BREAK.
REQ-019 BREAK SHALL remain until rx_s=1, then go to IDLE; no new frame starts within BREAK.
REQ-020 Handshake: valid=1 and ack=1 in a cycle SHALL clear valid next cycle; data and frame_err unchanged.
REQ-021 Completion while valid=1 and no ack that cycle SHALL overwrite data/frame_err, keep valid=1, set overrun.
REQ-022 Completion coinciding with ack SHALL load new byte, keep valid=1, not set overrun.
REQ-023 Bit counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, wrap to 0 at CLKS_PER_BIT-1; bit index DATA_BITS-wide range only.
REQ-024 Receiver SHALL accept back-to-back frames: start bit detectable first IDLE cycle after STOP.

Reset
REQ-025 rst=0 at rising edge SHALL force: state IDLE, counters 0, sync flops 1, data 0, valid 0, frame_err 0, overrun 0, busy 0.
REQ-026 Reset mid-frame SHALL discard partial byte; no valid pulse for it after release.
REQ-027 First frame recognised after release SHALL be one whose start edge occurs after rx_s reads 1 in IDLE.

Structure
REQ-028 Shared package uart_pkg SHALL hold state enum (IDLE, START, DATA, STOP, BREAK), default CLKS_PER_BIT=208, DATA_BITS=8.
REQ-029 Synchronizer SHALL be sub-module uart_sync2 (refclk, rst, d, q; reset value parameterised, 1 here).
REQ-030 Remaining logic (FSM, counters, shift, output register) SHALL be in uart_rx; target 150-250 lines.

Verification
REQ-031 Frame 0xA5, 208 cycles/bit, good stop -> valid=1 with data=0xA5, frame_err=0, within 2+104+9*208+1 cycles of start edge; ack clears valid next cycle.
REQ-032 rx low pulse of 50 cycles in IDLE -> return to IDLE, no valid, busy low again by cycle ~107.
REQ-033 Frame 0x3C with stop held low 3 bit-times -> valid=1, data=0x3C, frame_err=1; no new frame until rx high; next frame 0x81 received correctly.
REQ-034 Frames 0x11 then 0x22 back-to-back, no ack -> data=0x22, valid=1, overrun=1; repeat with ack on 0x22 completion cycle -> overrun unchanged from reset value 0.
REQ-035 rst=0 asserted during bit 4 of 0xFF, released, then frame 0x5A -> only 0x5A delivered; all outputs 0 during reset.
REQ-036 Bit timing ±2% (204 and 212 cycles/bit), frame 0x69 -> data=0x69, frame_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice: FSM state encoding and
// default frame timing.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DFLT = 208;
  localparam int unsigned DATA_BITS_DFLT    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input, with a parameterised
// reset value so an idle-high line reads idle straight out of reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic refclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// RS232 receiver: start-bit qualification at mid-bit, LSB-first data capture,
// stop-bit check with break handling, and a valid/ack output register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  parameter int unsigned DATA_BITS    = DATA_BITS_DFLT
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);

  logic rx_s;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 done;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .refclk (refclk),
    .rst    (rst),
    .d      (rx),
    .q      (rx_s)
  );

  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Mid-bit re-check rejects glitches shorter than half a bit.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == BIT_LAST) state_d = STOP;
          else                   idx_d   = idx_q + IW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          done    = 1'b1;
          state_d = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    // A completion wins over ack; it only counts as overrun if the old byte
    // was still unconsumed at that edge.
    if (done) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ferr_d  = ~rx_s;
      if (valid_q && !ack) ovr_d = 1'b1;
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives RS232 frames, predicts deliveries from frame
// contents and the receiver's fixed start-edge-to-delivery latency.
module tb_uart_rx;

  localparam int P   = 208;
  localparam int DUE = 3 + P / 2 + 9 * P;  // 2 sync + 1 detect + half bit + 8 data + stop

  logic       refclk = 1'b0;
  logic       rst    = 1'b0;
  logic       rx     = 1'b1;
  logic       ack    = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  always #5 refclk = ~refclk;

  uart_rx #(.CLKS_PER_BIT(P), .DATA_BITS(8)) dut (
    .refclk    (refclk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ack       (ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct {
    int         due;
    logic [7:0] d;
    logic       fe;
  } exp_t;

  exp_t       pend[$];
  int         cyc    = 0;
  int         n_cmp  = 0;
  int         n_bad  = 0;
  bit         chk_en = 1'b0;
  logic       m_valid = 1'b0, m_fe = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: deliveries happen at their scheduled cycle, ack consumes.
  always @(posedge refclk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_fe    <= 1'b0;
      m_ovr   <= 1'b0;
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due == cyc + 1) begin
      if (m_valid && !ack) m_ovr <= 1'b1;
      m_valid <= 1'b1;
      m_data  <= pend[0].d;
      m_fe    <= pend[0].fe;
      void'(pend.pop_front());
    end else if (m_valid && ack) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge refclk) begin
    if (chk_en) begin
      chk("valid", 32'(valid), 32'(m_valid));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (m_valid) begin
        chk("data", 32'(data), 32'(m_data));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Caller is always 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] b, input int cpb, input int stop_low_bits);
    exp_t e;
    e.due = cyc + DUE;
    e.d   = b;
    e.fe  = (stop_low_bits > 0);
    pend.push_back(e);
    rx = 1'b0;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(cpb);
    end
    if (stop_low_bits > 0) begin
      rx = 1'b0;
      tick(stop_low_bits * cpb);
    end
    rx = 1'b1;
    tick(cpb);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic expect_byte(input string nm, input logic [7:0] d, input logic fe);
    chk({nm, "_valid"}, 32'(valid), 32'd1);
    chk({nm, "_data"}, 32'(data), 32'(d));
    chk({nm, "_ferr"}, 32'(frame_err), 32'(fe));
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    ack = 1'b0;
    tick(5);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst    = 1'b1;
    chk_en = 1'b1;
    tick(10);

    // Nominal frame, then ack clears valid and leaves data alone.
    send_frame(8'hA5, P, 0);
    expect_byte("a5", 8'hA5, 1'b0);
    ack_pulse();
    chk("a5_ack_valid", 32'(valid), 32'd0);
    chk("a5_ack_data", 32'(data), 32'hA5);
    tick(20);

    // 50-cycle glitch must be rejected at the mid-bit check.
    rx = 1'b0;
    tick(50);
    rx = 1'b1;
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    tick(60);
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    chk("glitch_valid", 32'(valid), 32'd0);
    tick(20);

    // Stop bit held low into a break.
    fork
      send_frame(8'h3C, P, 3);
      begin
        tick(DUE + 200);
        chk("break_busy", 32'(busy), 32'd1);
        expect_byte("3c", 8'h3C, 1'b1);
      end
    join
    ack_pulse();
    tick(20);
    send_frame(8'h81, P, 0);
    expect_byte("81", 8'h81, 1'b0);
    ack_pulse();
    tick(20);

    // Back-to-back with no ack: second byte overwrites and flags overrun.
    send_frame(8'h11, P, 0);
    send_frame(8'h22, P, 0);
    expect_byte("b2b", 8'h22, 1'b0);
    chk("b2b_ovr", 32'(overrun), 32'd1);
    rst = 1'b0;
    tick(3);
    chk("ovr_cleared", 32'(overrun), 32'd0);
    rst = 1'b1;
    tick(10);

    // Same pair, ack coincides with the second completion: no overrun.
    fork
      begin
        send_frame(8'h11, P, 0);
        send_frame(8'h22, P, 0);
      end
      begin
        tick(10 * P + DUE - 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
      end
    join
    expect_byte("b2b_ack", 8'h22, 1'b0);
    chk("b2b_ack_ovr", 32'(overrun), 32'd0);
    ack_pulse();
    tick(20);

    // Reset during bit 4 of 0xFF discards it.
    fork
      send_frame(8'hFF, P, 0);
      begin
        tick(3 + P / 2 + 4 * P + 100);
        rst = 1'b0;
        tick(2);
        chk("mid_rst_data", 32'(data), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick(2);
        rst = 1'b1;
      end
    join
    chk("ff_dropped", 32'(valid), 32'd0);
    tick(20);
    send_frame(8'h5A, P, 0);
    expect_byte("5a", 8'h5A, 1'b0);
    ack_pulse();
    tick(20);

    // +/-2% sender bit rate.
    send_frame(8'h69, 204, 0);
    expect_byte("fast", 8'h69, 1'b0);
    ack_pulse();
    tick(20);
    send_frame(8'h69, 212, 0);
    expect_byte("slow", 8'h69, 1'b0);
    ack_pulse();
    tick(20);

    chk("pending_empty", 32'(pend.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
